// File: rtl/rv32i_ctrl_pkg.sv
// rv32i_ctrl_pkg: FSM states, next-PC and writeback encodings, instruction class flags.
package rv32i_ctrl_pkg;
    typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WB, HALT} state_t;
    localparam logic [1:0] PC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_IMM   = 2'd1;
    localparam logic [1:0] PC_RS1   = 2'd2;
    localparam logic [2:0] RF_ALU   = 3'd0;
    localparam logic [2:0] RF_LOAD  = 3'd1;
    localparam logic [2:0] RF_IMM   = 3'd2;
    localparam logic [2:0] RF_PCIMM = 3'd3;
    localparam logic [2:0] RF_PC4   = 3'd4;
    typedef struct packed {
        logic r;
        logic i;
        logic il;
        logic s;
        logic b;
        logic lui;
        logic auipc;
        logic jal;
        logic jalr;
    } iclass_t;
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational opcode/funct3/funct7 decode into datapath controls and class flags.
`include "define.sv"
module ctrl_decode
    import rv32i_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W = 4
) (
    input  logic [6:0]            opcode,
    input  logic [2:0]            funct3,
    input  logic                  funct7_5,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  alu_src_b,
    output logic [2:0]            rfwd_src,
    output iclass_t               cls
);
    logic [3:0] ac;
    always_comb begin
        cls       = '0;
        cls.r     = opcode == `OP_R;
        cls.i     = opcode == `OP_I;
        cls.il    = opcode == `OP_IL;
        cls.s     = opcode == `OP_S;
        cls.b     = opcode == `OP_B;
        cls.lui   = opcode == `OP_LUI;
        cls.auipc = opcode == `OP_AUIPC;
        cls.jal   = opcode == `OP_JAL;
        cls.jalr  = opcode == `OP_JALR;
        // funct7[5] only distinguishes SRAI from SRLI among immediates
        ac = cls.r ? {funct7_5, funct3} :
             cls.i ? {funct3 == 3'b101 && funct7_5, funct3} :
             cls.b ? {1'b0, funct3} : 4'b0000;
        alu_control = ALU_CTRL_W'(ac);
        alu_src_b   = cls.i | cls.il | cls.s | cls.jalr;
        rfwd_src    = cls.il ? RF_LOAD :
                      cls.lui ? RF_IMM :
                      cls.auipc ? RF_PCIMM :
                      (cls.jal | cls.jalr) ? RF_PC4 : RF_ALU;
    end
endmodule

// File: rtl/define.sv
// define.sv: RV32I base opcode macros shared by the control decoder.
`ifndef DEFINE_SV
`define DEFINE_SV
`define OP_R     7'b0110011
`define OP_I     7'b0010011
`define OP_IL    7'b0000011
`define OP_S     7'b0100011
`define OP_B     7'b1100011
`define OP_LUI   7'b0110111
`define OP_AUIPC 7'b0010111
`define OP_JAL   7'b1101111
`define OP_JALR  7'b1100111
`endif

// File: rtl/mcycle_ctrl.sv
// mcycle_ctrl: multi-cycle RV32I control FSM (FETCH/DECODE/EXECUTE/MEM/WB/HALT).
// Define ILLEGAL_TRAP_EN to halt on undefined opcodes; otherwise they retire as NOPs.
module mcycle_ctrl
    import rv32i_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           instr_code,
    input  logic                  btaken,
    input  logic                  d_ready,
    output logic                  ir_en,
    output logic                  pc_en,
    output logic [1:0]            pc_sel,
    output logic                  reg_wr_en,
    output logic                  alu_src_b,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic [2:0]            rfwd_src,
    output logic                  d_req,
    output logic                  d_wr_en,
    output logic                  illegal
);
    state_t st, nxt;
    iclass_t cls;
    logic dp_on, dec_src_b, unused_bits;
    logic [ALU_CTRL_W-1:0] dec_ac;
    logic [2:0] dec_rf;
    assign unused_bits = ^{instr_code[31], instr_code[29:15], instr_code[11:7]};
    ctrl_decode #(.ALU_CTRL_W(ALU_CTRL_W)) u_dec (
        .opcode     (instr_code[6:0]),
        .funct3     (instr_code[14:12]),
        .funct7_5   (instr_code[30]),
        .alu_control(dec_ac),
        .alu_src_b  (dec_src_b),
        .rfwd_src   (dec_rf),
        .cls        (cls)
    );
    always_ff @(posedge clk or posedge reset)
        if (reset) st <= FETCH;
        else st <= nxt;
    // outputs are gated by reset so they drop asynchronously, even mid-MEM
    always_comb begin
        nxt       = st;
        ir_en     = 1'b0;
        pc_en     = 1'b0;
        pc_sel    = PC_PLUS4;
        reg_wr_en = 1'b0;
        d_req     = 1'b0;
        d_wr_en   = 1'b0;
        illegal   = 1'b0;
        dp_on     = 1'b0;
        if (!reset) begin
            case (st)
                FETCH: begin
                    ir_en = 1'b1;
                    nxt   = DECODE;
                end
                DECODE: begin
                    dp_on = 1'b1;
                    if (|cls) nxt = EXECUTE;
                    else begin
`ifdef ILLEGAL_TRAP_EN
                        nxt = HALT;
`else
                        pc_en = 1'b1;
                        nxt   = FETCH;
`endif
                    end
                end
                EXECUTE: begin
                    dp_on = 1'b1;
                    if (cls.b) begin
                        pc_en  = 1'b1;
                        pc_sel = btaken ? PC_IMM : PC_PLUS4;
                        nxt    = FETCH;
                    end else nxt = (cls.s | cls.il) ? MEM : WB;
                end
                MEM: begin
                    dp_on   = 1'b1;
                    d_req   = 1'b1;
                    d_wr_en = cls.s;
                    if (d_ready) begin
                        pc_en = cls.s;
                        nxt   = cls.s ? FETCH : WB;
                    end
                end
                WB: begin
                    dp_on     = 1'b1;
                    reg_wr_en = 1'b1;
                    pc_en     = 1'b1;
                    pc_sel    = cls.jal ? PC_IMM : cls.jalr ? PC_RS1 : PC_PLUS4;
                    nxt       = FETCH;
                end
`ifdef ILLEGAL_TRAP_EN
                HALT: illegal = 1'b1;
`endif
                default: nxt = FETCH;
            endcase
        end
        alu_control = dp_on ? dec_ac : '0;
        alu_src_b   = dp_on & dec_src_b;
        rfwd_src    = dp_on ? dec_rf : RF_ALU;
    end
endmodule

// File: tb/tb_mcycle_ctrl.sv
// tb_mcycle_ctrl: table-driven per-instruction retirement checks plus reset and trap sequences.
module tb_mcycle_ctrl;
    logic clk = 1'b0, reset = 1'b1, btaken = 1'b0, d_ready = 1'b0;
    logic [31:0] instr_code = 32'h002081B3;
    logic ir_en, pc_en, reg_wr_en, alu_src_b, d_req, d_wr_en, illegal;
    logic [1:0] pc_sel;
    logic [3:0] alu_control;
    logic [2:0] rfwd_src;
    int n_vec = 0, n_bad = 0;

    mcycle_ctrl dut (
        .clk(clk), .reset(reset), .instr_code(instr_code), .btaken(btaken), .d_ready(d_ready),
        .ir_en(ir_en), .pc_en(pc_en), .pc_sel(pc_sel), .reg_wr_en(reg_wr_en), .alu_src_b(alu_src_b),
        .alu_control(alu_control), .rfwd_src(rfwd_src), .d_req(d_req), .d_wr_en(d_wr_en), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic        bt;
        int          nw;
        int          cyc;
        int          rwe;
        logic [1:0]  ps;
        int          mem;
        logic        dwr;
        logic        dp;
        logic [3:0]  ac;
        logic        sb;
        logic [2:0]  rf;
    } vec_t;
    vec_t vt[16];
    int nv;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] outs();
        return {ir_en, pc_en, pc_sel, reg_wr_en, alu_src_b, alu_control, rfwd_src, d_req, d_wr_en, illegal};
    endfunction

    // entered at posedge+1 with the DUT in FETCH; runs one instruction to its pc_en cycle
    task automatic run(input int idx, input vec_t v);
        int cyc = 0, mem = 0, pce = 0, rwe = 0, ire = 0;
        logic dwr = 1'b0, ill = 1'b0, sb = 1'b0;
        logic [1:0] ps = 2'd0;
        logic [3:0] ac = 4'd0;
        logic [2:0] rf = 3'd0;
        bit done = 0;
        instr_code = v.instr;
        btaken = v.bt;
        while (!done && cyc < 40) begin
            d_ready = mem >= v.nw;
            @(negedge clk);
            cyc++;
            if (cyc == 1) chk($sformatf("v%0d.fetch_ir_en", idx), ir_en, 1);
            ire += int'(ir_en);
            if (cyc == 3) begin
                ac = alu_control;
                sb = alu_src_b;
                rf = rfwd_src;
            end
            if (d_req) begin
                mem++;
                dwr |= d_wr_en;
            end
            rwe += int'(reg_wr_en);
            ill |= illegal;
            if (pc_en) begin
                pce++;
                ps = pc_sel;
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        chk($sformatf("v%0d.cycles", idx), cyc, v.cyc);
        chk($sformatf("v%0d.ir_en_count", idx), ire, 1);
        chk($sformatf("v%0d.pc_en_count", idx), pce, 1);
        chk($sformatf("v%0d.reg_wr_en_count", idx), rwe, v.rwe);
        chk($sformatf("v%0d.pc_sel", idx), ps, v.ps);
        chk($sformatf("v%0d.d_req_cycles", idx), mem, v.mem);
        chk($sformatf("v%0d.d_wr_en", idx), dwr, v.dwr);
        chk($sformatf("v%0d.illegal", idx), ill, 0);
        if (v.dp) begin
            chk($sformatf("v%0d.alu_control", idx), ac, v.ac);
            chk($sformatf("v%0d.alu_src_b", idx), sb, v.sb);
            chk($sformatf("v%0d.rfwd_src", idx), rf, v.rf);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int rw;
        bit seen;
        //          instr         bt nw cyc rwe ps mem dwr dp ac  sb rf
        vt[0]  = '{32'h002081B3, 0, 0, 4, 1, 0, 0, 0, 1, 0,  0, 0};
        vt[1]  = '{32'h402081B3, 0, 0, 4, 1, 0, 0, 0, 1, 8,  0, 0};
        vt[2]  = '{32'h40315093, 0, 0, 4, 1, 0, 0, 0, 1, 13, 1, 0};
        vt[3]  = '{32'hC0000093, 0, 0, 4, 1, 0, 0, 0, 1, 0,  1, 0};
        vt[4]  = '{32'h123450B7, 0, 0, 4, 1, 0, 0, 0, 1, 0,  0, 2};
        vt[5]  = '{32'h00000097, 0, 0, 4, 1, 0, 0, 0, 1, 0,  0, 3};
        vt[6]  = '{32'h000000EF, 0, 0, 4, 1, 1, 0, 0, 1, 0,  0, 4};
        vt[7]  = '{32'h000100E7, 0, 0, 4, 1, 2, 0, 0, 1, 0,  1, 4};
        vt[8]  = '{32'h00802283, 0, 2, 7, 1, 0, 3, 0, 1, 0,  1, 1};
        vt[9]  = '{32'h00802283, 0, 0, 5, 1, 0, 1, 0, 1, 0,  1, 1};
        vt[10] = '{32'h00502623, 0, 0, 4, 0, 0, 1, 1, 1, 0,  1, 0};
        vt[11] = '{32'h00502623, 0, 1, 5, 0, 0, 2, 1, 1, 0,  1, 0};
        vt[12] = '{32'h00000463, 1, 0, 3, 0, 1, 0, 0, 1, 0,  0, 0};
        vt[13] = '{32'h00000463, 0, 0, 3, 0, 0, 0, 0, 1, 0,  0, 0};
        vt[14] = '{32'h00004463, 1, 0, 3, 0, 1, 0, 0, 1, 4,  0, 0};
        nv = 15;
`ifndef ILLEGAL_TRAP_EN
        vt[15] = '{32'hFFFFFFFF, 0, 0, 2, 0, 0, 0, 0, 0, 0,  0, 0};
        nv = 16;
`endif
        #3;
        chk("reset_outputs", outs(), 16'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset_held_outputs", outs(), 16'h0);
        reset = 1'b0;
        for (int i = 0; i < nv; i++) run(i, vt[i]);

        // reset pulse in the middle of a stalled load
        instr_code = 32'h00802283;
        d_ready = 1'b0;
        rw = 0;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            rw += int'(reg_wr_en);
            seen = d_req;
            @(posedge clk);
            #1;
        end
        chk("midmem_reached", seen, 1);
        chk("midmem_d_req_held", d_req, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("midmem_reset_outputs", outs(), 16'h0);
        @(posedge clk);
        #1;
        chk("midmem_reset_after_edge", outs(), 16'h0);
        reset = 1'b0;
        chk("midmem_no_reg_wr", rw, 0);
        run(100, vt[9]);

`ifdef ILLEGAL_TRAP_EN
        instr_code = 32'hFFFFFFFF;
        @(negedge clk);
        chk("trap_fetch", ir_en, 1);
        @(negedge clk);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk($sformatf("trap_halt%0d", c), outs(), 16'h0001);
        end
        #2;
        reset = 1'b1;
        #1;
        chk("trap_reset_clears", outs(), 16'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        run(101, vt[0]);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
